// File: rtl/apb3_sram_target.sv
// APB3 completer fronting a word-organised scratch SRAM.
// Adds a fixed number of wait states per access, answers misaligned,
// out-of-range and malformed transfers with PSLVERR, and keeps a
// saturating count of error completions for debug.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | no transfer in flight; waiting for a setup phase
// S_ACCESS | setup accepted; counting wait states, then completing
// S_ERRDONE| access phase arrived without a setup; one-cycle error reply

module apb3_sram_target #(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 32,
    parameter int WAIT_STATES = 1
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    output logic                  PREADY,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  PSLVERR,
    output logic [7:0]            ERR_CNT
);

    localparam int          IDX_W   = ADDR_WIDTH - 2;
    localparam int          MEM_AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] DEPTH_U = 32'(DEPTH);
    localparam logic [3:0]  WS_L    = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACCESS  = 2'd1,
        S_ERRDONE = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [MEM_AW-1:0]       addr_q, addr_d;
    logic                    wr_q, wr_d;
    logic                    bad_q, bad_d;
    logic [DATA_WIDTH-1:0]   prdata_q;
    logic [7:0]              err_cnt_q, err_cnt_d;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic [IDX_W-1:0]        idx;
    logic [MEM_AW-1:0]       mem_idx;
    logic                    bad_setup;
    logic                    setup;
    logic                    complete;
    logic                    abort;
    logic                    err_evt;

    // Address decode of the bus address as presented in the setup phase
    assign idx       = PADDR[ADDR_WIDTH-1:2];
    assign mem_idx   = idx[MEM_AW-1:0];
    assign bad_setup = (PADDR[1:0] != 2'b00) || (32'(idx) >= DEPTH_U);

    assign setup    = (state_q == S_IDLE) && PSEL && !PENABLE;
    assign complete = (state_q == S_ACCESS) && PSEL && PENABLE && (cnt_q == 4'd0);
    assign abort    = (state_q == S_ACCESS) && !PSEL;
    assign err_evt  = (complete && bad_q) || (state_q == S_ERRDONE);

    // State register
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (PSEL && !PENABLE) begin
                    state_d = S_ACCESS;
                end else if (PSEL && PENABLE) begin
                    state_d = S_ERRDONE;
                end
            end
            S_ACCESS: begin
                if (abort || complete) begin
                    state_d = S_IDLE;
                end
            end
            S_ERRDONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Bus response outputs, decoded from registered state only
    always_comb begin
        PREADY  = 1'b0;
        PSLVERR = 1'b0;
        case (state_q)
            S_ACCESS: begin
                PREADY  = (cnt_q == 4'd0);
                PSLVERR = (cnt_q == 4'd0) && bad_q;
            end
            S_ERRDONE: begin
                PREADY  = 1'b1;
                PSLVERR = 1'b1;
            end
            default: begin
                PREADY  = 1'b0;
                PSLVERR = 1'b0;
            end
        endcase
    end

    // Next values for the transfer context, wait counter and error counter
    always_comb begin
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wr_d      = wr_q;
        bad_d     = bad_q;
        err_cnt_d = err_cnt_q;
        if (setup) begin
            cnt_d  = WS_L;
            addr_d = mem_idx;
            wr_d   = PWRITE;
            bad_d  = bad_setup;
        end else if ((state_q == S_ACCESS) && PSEL && (cnt_q != 4'd0)) begin
            cnt_d = cnt_q - 4'd1;
        end
        if (err_evt && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    // Transfer context and counters
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            cnt_q     <= 4'd0;
            addr_q    <= '0;
            wr_q      <= 1'b0;
            bad_q     <= 1'b0;
            err_cnt_q <= 8'd0;
        end else begin
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wr_q      <= wr_d;
            bad_q     <= bad_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // Read port: data fetched at the setup edge so it is stable for the whole access phase
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            prdata_q <= '0;
        end else if (setup) begin
            if (!PWRITE && !bad_setup) begin
                prdata_q <= mem[mem_idx];
            end else begin
                prdata_q <= '0;
            end
        end else if (abort || complete) begin
            prdata_q <= '0;
        end
    end

    // Write port: PWDATA taken at the completion edge; reset suppresses the write
    always_ff @(posedge PCLK) begin
        if (!PRESET && complete && wr_q && !bad_q) begin
            mem[addr_q] <= PWDATA;
        end
    end

    assign PRDATA  = prdata_q;
    assign ERR_CNT = err_cnt_q;

endmodule

// File: tb/tb_apb3_sram_target.sv
// Bench for apb3_sram_target: three instances with 1, 0 and 3 wait states,
// directed scenarios plus randomized transfers against an array-based model.

module tb_apb3_sram_target;

    localparam int NDUT  = 3;
    localparam int DEPTH = 32;

    logic        clk;
    logic        preset  [NDUT];
    logic        psel    [NDUT];
    logic        penable [NDUT];
    logic        pwrite  [NDUT];
    logic [7:0]  paddr   [NDUT];
    logic [31:0] pwdata  [NDUT];
    logic        pready  [NDUT];
    logic [31:0] prdata  [NDUT];
    logic        pslverr [NDUT];
    logic [7:0]  err_cnt [NDUT];

    logic [31:0] mdl_mem [NDUT][DEPTH];
    int          mdl_err [NDUT];

    int n_cmp = 0;
    int n_mis = 0;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        apb3_sram_target #(
            .ADDR_WIDTH (8),
            .DATA_WIDTH (32),
            .DEPTH      (DEPTH),
            .WAIT_STATES((g == 0) ? 1 : ((g == 1) ? 0 : 3))
        ) u_dut (
            .PCLK    (clk),
            .PRESET  (preset[g]),
            .PSEL    (psel[g]),
            .PENABLE (penable[g]),
            .PWRITE  (pwrite[g]),
            .PADDR   (paddr[g]),
            .PWDATA  (pwdata[g]),
            .PREADY  (pready[g]),
            .PRDATA  (prdata[g]),
            .PSLVERR (pslverr[g]),
            .ERR_CNT (err_cnt[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int ws_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 0 : 3);
    endfunction

    function automatic bit is_bad(input logic [7:0] addr);
        return ((int'(addr) % 4) != 0) || ((int'(addr) / 4) >= DEPTH);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp_v);
        end
    endtask

    // Called at a negedge; returns at the negedge after the completion edge
    // with the bus idle, so consecutive calls run back-to-back.
    task automatic apb_xfer(input int k, input bit wr, input logic [7:0] addr,
                            input logic [31:0] wdata, input bit scramble);
        int          waits;
        bit          done;
        logic [31:0] rd;
        logic        err;
        bit          bad;
        logic [31:0] exp_rd;
        string       pfx;
        pfx    = $sformatf("d%0d %s@%02h", k, wr ? "wr" : "rd", addr);
        bad    = is_bad(addr);
        exp_rd = bad ? 32'h0 : mdl_mem[k][int'(addr) / 4];
        rd     = '0;
        err    = 1'b0;
        psel[k]    = 1'b1;
        penable[k] = 1'b0;
        pwrite[k]  = wr;
        paddr[k]   = addr;
        pwdata[k]  = wdata;
        @(negedge clk);
        penable[k] = 1'b1;
        if (scramble) begin
            paddr[k]  = 8'($urandom);
            pwrite[k] = ~wr;
        end
        waits = 0;
        done  = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            if (pready[k] === 1'b1) begin
                done = 1'b1;
                rd   = prdata[k];
                err  = pslverr[k];
            end else begin
                waits++;
                @(negedge clk);
            end
        end
        if (!done) begin
            chk({pfx, " ready_timeout"}, 32'd0, 32'd1);
        end else begin
            chk({pfx, " waits"}, 32'(waits), 32'(ws_of(k)));
            chk({pfx, " slverr"}, {31'd0, err}, {31'd0, bad});
            if (!wr) chk({pfx, " rdata"}, rd, exp_rd);
        end
        if (wr && !bad) mdl_mem[k][int'(addr) / 4] = wdata;
        if (bad && mdl_err[k] < 255) mdl_err[k]++;
        @(negedge clk);
        chk({pfx, " err_cnt"}, {24'd0, err_cnt[k]}, 32'(mdl_err[k]));
        chk({pfx, " ready_after"}, {31'd0, pready[k]}, 32'd0);
        chk({pfx, " rdata_clr"}, prdata[k], 32'd0);
        psel[k]    = 1'b0;
        penable[k] = 1'b0;
    endtask

    task automatic rand_addr(output logic [7:0] a);
        int r;
        r = $urandom_range(0, 9);
        if (r < 7)       a = {6'($urandom_range(0, 31)), 2'b00};
        else if (r == 7) a = {6'($urandom), 2'($urandom_range(1, 3))};
        else             a = {6'($urandom_range(32, 63)), 2'b00};
    endtask

    initial begin
        logic [7:0] a;
        for (int k = 0; k < NDUT; k++) begin
            preset[k]  = 1'b1;
            psel[k]    = 1'b0;
            penable[k] = 1'b0;
            pwrite[k]  = 1'b0;
            paddr[k]   = '0;
            pwdata[k]  = '0;
            mdl_err[k] = 0;
        end
        repeat (2) @(negedge clk);
        for (int k = 0; k < NDUT; k++) begin
            chk($sformatf("d%0d rst_pready", k), {31'd0, pready[k]}, 32'd0);
            chk($sformatf("d%0d rst_pslverr", k), {31'd0, pslverr[k]}, 32'd0);
            chk($sformatf("d%0d rst_prdata", k), prdata[k], 32'd0);
            chk($sformatf("d%0d rst_errcnt", k), {24'd0, err_cnt[k]}, 32'd0);
            preset[k] = 1'b0;
        end
        @(negedge clk);

        // Give every word a defined value, back-to-back
        for (int k = 0; k < NDUT; k++)
            for (int w = 0; w < DEPTH; w++)
                apb_xfer(k, 1'b1, 8'(w * 4), $urandom, 1'b0);

        // One wait state: write then read 0x2C
        apb_xfer(0, 1'b1, 8'h2C, 32'h0000_0001, 1'b0);
        apb_xfer(0, 1'b0, 8'h2C, 32'h0, 1'b0);

        // Misaligned and out-of-range reads
        apb_xfer(0, 1'b0, 8'h81, 32'h0, 1'b0);
        apb_xfer(0, 1'b0, 8'h80, 32'h0, 1'b0);
        chk("d0 errcnt_two", {24'd0, err_cnt[0]}, 32'd2);

        // Out-of-range write must not alias into word 0
        apb_xfer(0, 1'b1, 8'h00, 32'h0000_1234, 1'b0);
        apb_xfer(0, 1'b1, 8'h80, 32'hDEAD_BEEF, 1'b0);
        apb_xfer(0, 1'b0, 8'h00, 32'h0, 1'b0);
        chk("d0 word0", mdl_mem[0][0], 32'h0000_1234);

        // Access phase without setup
        psel[0]    = 1'b1;
        penable[0] = 1'b1;
        @(negedge clk);
        chk("d0 noset_pready", {31'd0, pready[0]}, 32'd1);
        chk("d0 noset_pslverr", {31'd0, pslverr[0]}, 32'd1);
        psel[0]    = 1'b0;
        penable[0] = 1'b0;
        mdl_err[0]++;
        @(negedge clk);
        chk("d0 noset_errcnt", {24'd0, err_cnt[0]}, 32'(mdl_err[0]));
        chk("d0 noset_idle", {31'd0, pready[0]}, 32'd0);

        // Zero wait states
        apb_xfer(1, 1'b1, 8'h18, 32'hA5A5_5A5A, 1'b0);
        apb_xfer(1, 1'b0, 8'h18, 32'h0, 1'b0);

        // Reset on what would be the completion edge of a zero-wait write
        apb_xfer(1, 1'b1, 8'h08, 32'h1357_9BDF, 1'b0);
        apb_xfer(1, 1'b1, 8'h83, 32'h0, 1'b0);
        psel[1]    = 1'b1;
        penable[1] = 1'b0;
        pwrite[1]  = 1'b1;
        paddr[1]   = 8'h08;
        pwdata[1]  = 32'h5555_AAAA;
        @(negedge clk);
        penable[1] = 1'b1;
        preset[1]  = 1'b1;
        @(negedge clk);
        preset[1]  = 1'b0;
        psel[1]    = 1'b0;
        penable[1] = 1'b0;
        mdl_err[1] = 0;
        chk("d1 rstmid_pready", {31'd0, pready[1]}, 32'd0);
        chk("d1 rstmid_pslverr", {31'd0, pslverr[1]}, 32'd0);
        chk("d1 rstmid_errcnt", {24'd0, err_cnt[1]}, 32'd0);
        @(negedge clk);
        apb_xfer(1, 1'b0, 8'h08, 32'h0, 1'b0);
        apb_xfer(1, 1'b1, 8'h08, 32'h0F0F_F0F0, 1'b0);
        apb_xfer(1, 1'b0, 8'h08, 32'h0, 1'b0);

        // Initiator abort during a wait state
        apb_xfer(2, 1'b1, 8'h04, 32'h0BAD_CAFE, 1'b0);
        psel[2]    = 1'b1;
        penable[2] = 1'b0;
        pwrite[2]  = 1'b1;
        paddr[2]   = 8'h04;
        pwdata[2]  = 32'hFFFF_FFFF;
        @(negedge clk);
        penable[2] = 1'b1;
        chk("d2 abort_wait0", {31'd0, pready[2]}, 32'd0);
        @(negedge clk);
        chk("d2 abort_wait1", {31'd0, pready[2]}, 32'd0);
        psel[2]    = 1'b0;
        penable[2] = 1'b0;
        @(negedge clk);
        chk("d2 abort_idle", {31'd0, pready[2]}, 32'd0);
        chk("d2 abort_errcnt", {24'd0, err_cnt[2]}, 32'(mdl_err[2]));
        apb_xfer(2, 1'b0, 8'h04, 32'h0, 1'b0);

        // Randomized traffic with latched-control scrambling and idle gaps
        for (int k = 0; k < NDUT; k++) begin
            for (int n = 0; n < 60; n++) begin
                rand_addr(a);
                apb_xfer(k, 1'($urandom), a, $urandom, 1'($urandom));
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
        end

        // Error counter saturation
        for (int n = 0; n < 300; n++) begin
            a = {6'($urandom_range(32, 63)), 2'($urandom_range(0, 3))};
            apb_xfer(1, 1'(n % 2), a, $urandom, 1'b0);
        end
        chk("d1 err_sat", {24'd0, err_cnt[1]}, 32'd255);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/apb3_sram_target.md
Name: apb3_sram_target

Overview:
- APB3 completer placed directly downstream of the two-initiator APB3 mux; connects to the mux's APBT_* target port.
- Provides a word-organised on-chip scratch memory.
- Inserts a parameterised number of wait states, flags bad accesses on PSLVERR, and counts errors for debug.
- Serves as both a bring-up target and the standard completion model behind the mux.

Parameters:
ADDR_WIDTH, 8, width of PADDR (byte address)
DATA_WIDTH, 32, width of PWDATA/PRDATA; fixed at 32, any other value is unsupported
DEPTH, 32, number of 32-bit words implemented (1..2^(ADDR_WIDTH-2))
WAIT_STATES, 1, PREADY-low cycles inserted in the access phase (0..15)

Ports:
PCLK  in  1  clock; all logic on rising edge
PRESET  in  1  reset, synchronous, active-high
PSEL  in  1  APB select
PENABLE  in  1  APB enable (access phase)
PWRITE  in  1  1 = write, 0 = read
PADDR  in  ADDR_WIDTH  byte address
PWDATA  in  DATA_WIDTH  write data
PREADY  out  1  transfer completion
PRDATA  out  DATA_WIDTH  read data
PSLVERR  out  1  error response, valid only when PREADY=1
ERR_CNT  out  8  saturating count of completed transfers with PSLVERR=1

Behaviour:
- Reset: on a PCLK edge with PRESET=1:
  - state=IDLE, wait counter=0, PRDATA=0, PREADY=0, PSLVERR=0, ERR_CNT=0.
  - Memory contents are not cleared and are undefined after power-up.
- Reset mid-transfer aborts the transfer; no memory write occurs.
- Address decode: word index = PADDR[ADDR_WIDTH-1:2].
  - Error (bad) if PADDR[1:0]!=0 or index>=DEPTH.
- FSM states: IDLE, ACCESS, ERRDONE.
- IDLE:
  - PSEL=1, PENABLE=0 (setup): latch addr, write flag and bad flag; load counter with WAIT_STATES; go to ACCESS.
  - If setup is a read and the address is good: PRDATA <= mem[index] at this same edge, so data is valid throughout the access phase.
  - Bad read: PRDATA <= 0.
  - PSEL=1, PENABLE=1 with no preceding setup (protocol violation): go to ERRDONE.
- ACCESS:
  - PREADY = (counter==0), combinational from registers.
  - While counter!=0 and PSEL=1: counter decrements each cycle, PREADY=0.
  - With WAIT_STATES=0, PREADY=1 in the first access cycle.
- Completion edge (ACCESS, PSEL & PENABLE & PREADY):
  - Good write: mem[index] <= PWDATA.
  - Bad write: memory unchanged.
  - PSLVERR = latched bad flag, driven only while PREADY=1; otherwise 0.
  - ERR_CNT increments if bad, saturating at 255.
  - PRDATA cleared to 0; state -> IDLE.
- Back-to-back: a setup phase presented in the cycle after completion is accepted normally; there is no idle cycle requirement.
- Initiator abort: PSEL falls while in ACCESS before completion → IDLE; no write, no ERR_CNT change.
- Address and control changes during ACCESS are ignored; the latched values are used.
- ERRDONE: PREADY=1 and PSLVERR=1 for one cycle; ERR_CNT increments (saturating); → IDLE.
- The write path uses PWDATA sampled at the completion edge; PWDATA is not latched at setup.
- Read-during-write cannot occur: the block processes a single outstanding transfer.
- Memory is inferred synchronous RAM; one read port at setup, one write port at completion.

Test Plan:
- Write 0x0000_0001 to PADDR 0x2C, then read 0x2C with WAIT_STATES=1 → write completes on the 2nd access cycle (PREADY low 1 cycle); read returns 0x0000_0001, PSLVERR=0.
- WAIT_STATES=0: write 0xA5A5_5A5A to 0x18, read 0x18 → PREADY=1 in the first access cycle for both transfers; data 0xA5A5_5A5A.
- Read of PADDR 0x81 (misaligned) and of 0x80 with DEPTH=32 (out of range) → PSLVERR=1 with PREADY, PRDATA=0, ERR_CNT=2.
- Write 0xDEAD_BEEF to 0x80 (out of range), then read 0x00 after first writing 0x1234 there → PSLVERR=1 on the write; word 0 still reads 0x0000_1234.
- Drop PSEL during a wait state (WAIT_STATES=3) on a write of 0xFFFF_FFFF to 0x04 → no completion; subsequent read of 0x04 returns its previous value.
- Assert PRESET for one cycle during an access phase → PREADY/PSLVERR=0 and ERR_CNT=0 next cycle; a fresh write and read to 0x08 completes normally.
- Issue 300 bad transfers → ERR_CNT saturates at 255 and does not wrap.
